// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle add/sub/and/or plus an iterative shift-add multiplier.
// A start/busy/done handshake lets the pipeline stall while a multiply is in flight.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic {IDLE, MUL} state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b101;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_reg, a_n;
  logic [WIDTH-1:0] b_reg, b_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] data_n;
  logic             zero_n;
  logic             done_n;
  logic [WIDTH-1:0] single_res;
  logic [WIDTH-1:0] acc_sum;

  assign busy_o = (state == MUL);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      acc    <= '0;
      cnt    <= '0;
      data_o <= '0;
      zero_o <= 1'b1;
      done_o <= 1'b0;
    end else begin
      state  <= state_n;
      a_reg  <= a_n;
      b_reg  <= b_n;
      acc    <= acc_n;
      cnt    <= cnt_n;
      data_o <= data_n;
      zero_o <= zero_n;
      done_o <= done_n;
    end
  end

  // Undefined codes fall through to zero so they still complete with a done pulse.
  always_comb begin
    single_res = '0;
    case (ALUCtrl_i)
      OP_ADD:  single_res = data1_i + data2_i;
      OP_SUB:  single_res = data1_i - data2_i;
      OP_AND:  single_res = data1_i & data2_i;
      OP_OR:   single_res = data1_i | data2_i;
      default: single_res = '0;
    endcase
  end

  assign acc_sum = acc + (b_reg[0] ? a_reg : '0);

  always_comb begin
    state_n = state;
    a_n     = a_reg;
    b_n     = b_reg;
    acc_n   = acc;
    cnt_n   = cnt;
    data_n  = data_o;
    zero_n  = zero_o;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (ALUCtrl_i == OP_MUL) begin
            a_n     = data1_i;
            b_n     = data2_i;
            acc_n   = '0;
            cnt_n   = '0;
            state_n = MUL;
          end else begin
            data_n = single_res;
            zero_n = (single_res == '0);
            done_n = 1'b1;
          end
        end
      end
      MUL: begin
        acc_n = acc_sum;
        a_n   = a_reg << 1;
        b_n   = b_reg >> 1;
        cnt_n = cnt + CNT_W'(1);
        // The WIDTH-th iteration writes its sum straight to the result register.
        if (cnt == CNT_W'(WIDTH - 1)) begin
          data_n  = acc_sum;
          zero_n  = (acc_sum == '0);
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle at WIDTH=32.
// Outputs are sampled 1 time unit after each rising clock edge.
module tb_alu_multicycle;

  localparam int WIDTH = 32;

  logic             clk_i;
  logic             rst_i;
  logic             start_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;
  logic             busy_o;
  logic             done_o;

  int checks;
  int failures;
  int edges;
  int busy_cycles;
  int done_count;

  alu_multicycle #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .ALUCtrl_i(ALUCtrl_i),
    .data1_i  (data1_i),
    .data2_i  (data2_i),
    .data_o   (data_o),
    .zero_o   (zero_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Presents one request for a single edge; returns #1 after that edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i   = 1'b1;
    ALUCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  // Steps edges until done_o, counting edges and busy cycles.
  // mode 1 scrambles operands at edge 5; mode 2 requests an add while busy at edge 10.
  task automatic waitDone(input int mode);
    edges       = 0;
    busy_cycles = 0;
    done_count  = 0;
    while (!done_o && edges < 100) begin
      if (busy_o) busy_cycles++;
      if (mode == 1 && edges == 5) begin
        data1_i   = 32'd123;
        data2_i   = 32'd456;
        ALUCtrl_i = 3'b000;
      end
      if (mode == 2 && edges == 10) begin
        start_i   = 1'b1;
        ALUCtrl_i = 3'b010;
        data1_i   = 32'd1;
        data2_i   = 32'd1;
      end
      if (mode == 2 && edges == 11) start_i = 1'b0;
      @(posedge clk_i);
      #1;
      edges++;
      if (done_o) done_count++;
    end
    if (!done_o) begin
      checks++;
      failures++;
      $display("[TB] FAIL mul_timeout: got no done after %0d edges, expected done", edges);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_i     = 1'b0;
    start_i   = 1'b0;
    ALUCtrl_i = 3'b000;
    data1_i   = '0;
    data2_i   = '0;

    // Reset asserted between edges must take effect immediately.
    #2 rst_i = 1'b1;
    #1;
    checkOutput("rst_data", data_o, 32'h0);
    checkOutput("rst_zero", {31'b0, zero_o}, 32'h1);
    checkOutput("rst_busy", {31'b0, busy_o}, 32'h0);
    checkOutput("rst_done", {31'b0, done_o}, 32'h0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    applyStimulus(3'b010, 32'd7, 32'd5);
    checkOutput("add_data", data_o, 32'd12);
    checkOutput("add_zero", {31'b0, zero_o}, 32'h0);
    checkOutput("add_done", {31'b0, done_o}, 32'h1);
    checkOutput("add_busy", {31'b0, busy_o}, 32'h0);
    @(posedge clk_i);
    #1;
    checkOutput("add_done_drop", {31'b0, done_o}, 32'h0);
    checkOutput("add_hold", data_o, 32'd12);

    applyStimulus(3'b110, 32'd5, 32'd5);
    checkOutput("sub_data", data_o, 32'd0);
    checkOutput("sub_zero", {31'b0, zero_o}, 32'h1);

    applyStimulus(3'b110, 32'd3, 32'd5);
    checkOutput("sub_neg", data_o, 32'hFFFF_FFFE);

    applyStimulus(3'b000, 32'h0000_F0F0, 32'h0000_0FF0);
    checkOutput("and_data", data_o, 32'h0000_00F0);

    applyStimulus(3'b001, 32'h0000_F000, 32'h0000_000F);
    checkOutput("or_data", data_o, 32'h0000_F00F);
    checkOutput("or_zero", {31'b0, zero_o}, 32'h0);

    // Consecutive single-cycle ops: done stays high, data updates every edge.
    applyStimulus(3'b100, 32'd9, 32'd9);
    checkOutput("undef_data", data_o, 32'h0);
    checkOutput("undef_zero", {31'b0, zero_o}, 32'h1);
    checkOutput("undef_done", {31'b0, done_o}, 32'h1);
    checkOutput("undef_busy", {31'b0, busy_o}, 32'h0);

    applyStimulus(3'b010, 32'hFFFF_FFFF, 32'd1);
    checkOutput("add_wrap_data", data_o, 32'h0);
    checkOutput("add_wrap_zero", {31'b0, zero_o}, 32'h1);
    checkOutput("add_wrap_done", {31'b0, done_o}, 32'h1);
    @(posedge clk_i);
    #1;

    applyStimulus(3'b101, 32'd6, 32'd7);
    checkOutput("mul_start_busy", {31'b0, busy_o}, 32'h1);
    checkOutput("mul_start_done", {31'b0, done_o}, 32'h0);
    waitDone(1);
    checkOutput("mul_edges", edges, 32'd32);
    checkOutput("mul_busy_cycles", busy_cycles, 32'd32);
    checkOutput("mul_data", data_o, 32'd42);
    checkOutput("mul_zero", {31'b0, zero_o}, 32'h0);
    checkOutput("mul_busy_end", {31'b0, busy_o}, 32'h0);
    @(posedge clk_i);
    #1;
    checkOutput("mul_done_drop", {31'b0, done_o}, 32'h0);

    applyStimulus(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone(0);
    checkOutput("mul_ones_data", data_o, 32'd1);
    checkOutput("mul_ones_edges", edges, 32'd32);
    @(posedge clk_i);
    #1;

    applyStimulus(3'b101, 32'd3, 32'd4);
    waitDone(2);
    checkOutput("busy_ign_data", data_o, 32'd12);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i);
      #1;
      if (done_o) done_count++;
    end
    checkOutput("busy_ign_pulses", done_count, 32'd1);

    // Request accepted in the done cycle of a multiply.
    applyStimulus(3'b101, 32'd5, 32'd5);
    waitDone(0);
    checkOutput("b2b_mul_data", data_o, 32'd25);
    applyStimulus(3'b010, 32'd2, 32'd3);
    checkOutput("b2b_add_data", data_o, 32'd5);
    checkOutput("b2b_add_done", {31'b0, done_o}, 32'h1);
    @(posedge clk_i);
    #1;
    checkOutput("b2b_done_drop", {31'b0, done_o}, 32'h0);

    // Abort a multiply with reset, then run a fresh one.
    applyStimulus(3'b101, 32'd9, 32'd9);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk_i);
      #1;
    end
    #2 rst_i = 1'b1;
    #1;
    checkOutput("abort_busy", {31'b0, busy_o}, 32'h0);
    checkOutput("abort_data", data_o, 32'h0);
    checkOutput("abort_zero", {31'b0, zero_o}, 32'h1);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    done_count = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk_i);
      #1;
      if (done_o) done_count++;
    end
    checkOutput("abort_no_done", done_count, 32'd0);
    applyStimulus(3'b101, 32'd2, 32'd2);
    waitDone(0);
    checkOutput("after_abort_edges", edges, 32'd32);
    checkOutput("after_abort_data", data_o, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
Execute-stage ALU, directly downstream of the ALU control decoder; consumes its 3-bit ALU control code and the two register/immediate operands.
- add/sub/and/or complete in one cycle.
- mul (code 101) runs an iterative shift-add multiplier over WIDTH cycles.
- A start/busy/done handshake lets the multi-cycle datapath stall the pipeline while a multiply is in flight.
- Result and zero flag are registered and feed the MEM/WB stage and branch logic.

Parameters:
WIDTH, 32, operand and result width in bits; legal range 4..32.
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
clk_i  input  1  clock; all state changes on rising edge
rst_i  input  1  reset, asynchronous, active-high
start_i  input  1  request; sampled only when busy_o=0
ALUCtrl_i  input  3  op code: 010 add, 110 sub, 000 and, 001 or, 101 mul
data1_i  input  WIDTH  operand A (rs)
data2_i  input  WIDTH  operand B (rt or immediate)
data_o  output  WIDTH  registered result
zero_o  output  1  registered, 1 when data_o==0
busy_o  output  1  multiply in progress; upstream must hold/stall
done_o  output  1  one-cycle pulse: data_o/zero_o updated this cycle

Behaviour:
- Reset (asynchronous, any time including mid-multiply): state=IDLE, data_o=0, zero_o=1, busy_o=0, done_o=0, counter=0, internal accumulator/operand registers=0. An in-flight multiply is discarded.
- States: IDLE, MUL.
  - IDLE: on edge with start_i=1:
    - ALUCtrl_i != 101: data_o <= op(data1_i, data2_i); zero_o <= (result==0); done_o <= 1 for one cycle; stay IDLE. Latency is 1 edge.
    - ALUCtrl_i == 101: latch A, B; acc <= 0; counter <= 0; busy_o <= 1; go to MUL; done_o stays 0.
  - MUL: each edge:
    - if B[0], acc <= acc + A.
    - A <= A<<1; B <= B>>1 (logical); counter++.
    - On the edge where counter==WIDTH-1 (the WIDTH-th MUL edge): data_o <= final acc, zero_o updated, done_o <= 1, busy_o <= 0, go to IDLE.
- Multiply timing: start edge E0, result valid and done_o=1 in the cycle after edge E_WIDTH. For WIDTH=32, busy_o is high for exactly 32 cycles.
- Arithmetic, all modulo 2^WIDTH (no overflow/carry flag):
  - add/sub: two's complement wrap.
  - mul: low WIDTH bits of the product, identical for signed and unsigned operands. No early termination.
- Undefined codes (011, 100, 111) with start_i=1: data_o <= 0, zero_o <= 1, done_o pulses. Such codes never enter MUL.
- start_i while busy_o=1: ignored. No queuing, no effect on the running multiply.
- Inputs data1_i, data2_i, ALUCtrl_i may change freely while busy_o=1; only values latched at start are used.
- Back-to-back operation:
  - start_i may be asserted in the done_o cycle of a multiply (busy_o=0 there) and is accepted.
  - Consecutive single-cycle ops on consecutive edges give done_o high continuously, with data_o updating every edge.
- done_o is 0 in every cycle without a completion.
- data_o/zero_o hold their last values until the next completion.

Test Plan:
- Reset: assert rst_i mid-cycle with no clock edge -> data_o=0, zero_o=1, busy_o=0, done_o=0 immediately.
- Single-cycle ops (WIDTH=32):
  - add 7+5 -> data_o=12, done_o 1 cycle later, busy_o never high.
  - sub 5-5 -> data_o=0, zero_o=1.
  - and 0xF0F0&0x0FF0 -> 0x00F0.
  - or 0xF000|0x000F -> 0xF00F.
  - add 0xFFFFFFFF+1 -> data_o=0, zero_o=1.
- Multiply 6*7 -> busy_o high 32 cycles, done_o pulses exactly 32 edges after the start edge, data_o=42, zero_o=0. Multiply 0xFFFFFFFF*0xFFFFFFFF -> data_o=1. Operands changed mid-run do not affect the result.
- Start ignored while busy: start_i add 1+1 on cycle 10 of a 3*4 multiply -> only one done_o pulse, data_o=12.
- Back-to-back: assert start_i (add 2+3) in the mul done_o cycle -> next cycle data_o=5, done_o high two consecutive cycles.
- Reset mid-multiply: rst_i at cycle 15 of a multiply, then a new 2*2 request -> no done_o from the aborted op; second result is 4 after 32 cycles.
